// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and sizing for imem_responder; IMEM_PREFETCH_EN selects the two-entry prefetching build
package imem_pkg;

    // Tags are stored at this width; the responder's ADDR_W must not exceed it.
    localparam int IMEM_TAG_W = 30;

`ifdef IMEM_PREFETCH_EN
    localparam int IMEM_ENTRIES = 2;
`else
    localparam int IMEM_ENTRIES = 1;
`endif

    localparam int IMEM_IDX_W = 1;

    typedef enum logic {
        IDLE,
        BUSY
    } imem_state_t;

    typedef struct packed {
        logic                  valid;
        logic [IMEM_TAG_W-1:0] tag;
        logic [31:0]           word;
    } imem_entry_t;

endpackage

// File: rtl/imem_entry_buf.sv
// rtl/imem_entry_buf.sv - tagged instruction word buffer: tag compare, hit index, victim select, write port
// IMEM_PREFETCH_EN adds a second compare port used to look for the next sequential tag.
module imem_entry_buf
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_TAG_W
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [ADDR_W-1:0]     lookup_addr,
    output logic                  lookup_hit,
    output logic [IMEM_IDX_W-1:0] lookup_idx,
    output logic [31:0]           lookup_word,
`ifdef IMEM_PREFETCH_EN
    input  logic [ADDR_W-1:0]     probe_addr,
    output logic                  probe_hit,
`endif
    output logic [IMEM_IDX_W-1:0] victim_idx,
    input  logic                  touch_en,
    input  logic [IMEM_IDX_W-1:0] touch_idx,
    input  logic                  wr_en,
    input  logic [IMEM_IDX_W-1:0] wr_idx,
    input  logic [ADDR_W-1:0]     wr_tag,
    input  logic [31:0]           wr_word
);

    imem_entry_t           entries [IMEM_ENTRIES];
    logic [IMEM_IDX_W-1:0] mru_idx;

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_idx  = '0;
        lookup_word = '0;
        for (int i = 0; i < IMEM_ENTRIES; i++) begin
            if (entries[i].valid && (entries[i].tag == IMEM_TAG_W'(lookup_addr))) begin
                lookup_hit  = 1'b1;
                lookup_idx  = IMEM_IDX_W'(i);
                lookup_word = entries[i].word;
            end
        end
    end

`ifdef IMEM_PREFETCH_EN
    always_comb begin
        probe_hit = 1'b0;
        for (int i = 0; i < IMEM_ENTRIES; i++) begin
            if (entries[i].valid && (entries[i].tag == IMEM_TAG_W'(probe_addr))) begin
                probe_hit = 1'b1;
            end
        end
    end
`endif

    // Lowest invalid entry wins; with every entry valid, replace the one not most recently hit.
    always_comb begin
        victim_idx = (IMEM_ENTRIES > 1) ? IMEM_IDX_W'(~mru_idx) : '0;
        for (int i = IMEM_ENTRIES - 1; i >= 0; i--) begin
            if (!entries[i].valid) begin
                victim_idx = IMEM_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            for (int i = 0; i < IMEM_ENTRIES; i++) begin
                entries[i] <= '0;
            end
            mru_idx <= '0;
        end else begin
            if (wr_en) begin
                entries[wr_idx] <= '{valid: 1'b1, tag: IMEM_TAG_W'(wr_tag), word: wr_word};
            end
            if (touch_en) begin
                mru_idx <= touch_idx;
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch-side instruction word responder backed by a variable-latency memory port
// IMEM_PREFETCH_EN enables a speculative fill of the next sequential word after each response.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W = 30
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              ins_req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ins_res,
    output logic [31:0]       data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    imem_state_t           state_q, state_d;
    logic [ADDR_W-1:0]     fill_tag_q, fill_tag_d;
    logic [IMEM_IDX_W-1:0] fill_idx_q, fill_idx_d;

    logic                  lookup_hit;
    logic [IMEM_IDX_W-1:0] lookup_idx;
    logic [31:0]           lookup_word;
    logic [IMEM_IDX_W-1:0] victim_idx;

    logic live_req;
    logic hit;
    logic miss;
    logic fill_done;

    // The cycle carrying a response never starts a new lookup, so fetch can advance addr without a duplicate.
    assign live_req  = ins_req && !ins_res;
    assign hit       = live_req && lookup_hit;
    assign miss      = live_req && !lookup_hit;
    assign fill_done = (state_q == BUSY) && mem_ack;

    assign mem_req  = (state_q == BUSY);
    assign mem_addr = fill_tag_q;

`ifdef IMEM_PREFETCH_EN
    logic [ADDR_W-1:0]     resp_tag_q;
    logic [IMEM_IDX_W-1:0] resp_idx_q;
    logic [ADDR_W-1:0]     pf_tag;
    logic                  pf_hit;
    logic                  pf_go;

    assign pf_tag = resp_tag_q + ADDR_W'(1);
    // A response cycle can never carry a live request, so no demand miss competes here.
    assign pf_go  = ins_res && !pf_hit;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            resp_tag_q <= '0;
            resp_idx_q <= '0;
        end else if (hit) begin
            resp_tag_q <= addr;
            resp_idx_q <= lookup_idx;
        end
    end
`endif

    imem_entry_buf #(
        .ADDR_W (ADDR_W)
    ) u_entry_buf (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .lookup_addr (addr),
        .lookup_hit  (lookup_hit),
        .lookup_idx  (lookup_idx),
        .lookup_word (lookup_word),
`ifdef IMEM_PREFETCH_EN
        .probe_addr  (pf_tag),
        .probe_hit   (pf_hit),
`endif
        .victim_idx  (victim_idx),
        .touch_en    (hit),
        .touch_idx   (lookup_idx),
        .wr_en       (fill_done),
        .wr_idx      (fill_idx_q),
        .wr_tag      (fill_tag_q),
        .wr_word     (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d    = BUSY;
                    fill_tag_d = addr;
                    fill_idx_d = victim_idx;
                end
`ifdef IMEM_PREFETCH_EN
                else if (pf_go) begin
                    state_d    = BUSY;
                    fill_tag_d = pf_tag;
                    fill_idx_d = resp_idx_q ^ 1'b1;
                end
`endif
            end
            BUSY: begin
                // Fills always run to completion; a waiting miss is re-evaluated once back in IDLE.
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q    <= IDLE;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            ins_res    <= 1'b0;
            data       <= '0;
        end else begin
            state_q    <= state_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            ins_res    <= hit;
            if (hit) begin
                data <= lookup_word;
            end
        end
    end

endmodule
